rx_frame_ctrl: RTL and testbench
================================

// Module: rx_frame_ctrl
// PURPOSE
//  Receive-side frame controller that drives the stp_4bit serial-to-parallel shift register.
//  Synchronizes the async serial line and detects/validates the start bit.
//  Times mid-bit sampling and pulses shift_enable once per data bit.
//  Checks the stop bit, then captures the register's parallel word into a held output buffer
//  with ready/overrun/framing status.
// PARAMETERS
//  DATA_BITS     4   data bits per frame (= stp width); LSB transmitted first
//  CLKS_PER_BIT  10  clk cycles per bit period; must be >= 4; HALF = CLKS_PER_BIT/2 (floor)
// PORTS
//  clk            in   1          system clock, rising edge
//  n_rst          in   1          asynchronous, active-low reset
//  serial_in      in   1          raw async serial line, idles high
//  sr_data        in   DATA_BITS  parallel_out of the stp shift register
//  data_read      in   1          consumer has taken rx_data (1-cycle pulse)
//  serial_bit     out  1          synchronized line; drives stp serial_in
//  shift_enable   out  1          1-cycle pulse at each data-bit midpoint; drives stp shift_enable
//  rx_data        out  DATA_BITS  last good received word
//  data_ready     out  1          rx_data holds an unread word
//  framing_error  out  1          last frame had a low stop bit
//  overrun_error  out  1          a word was overwritten before being read
//  busy           out  1          frame reception in progress (state != IDLE)
// BEHAVIOUR
//  Reset (async, immediate, including mid-frame):
//   - state=IDLE; timer=0; all outputs 0.
//   - Both sync FFs and the edge-detect FF reset to 1, so no false start edge appears on release.
//  Sync: 2-FF synchronizer; serial_bit is the 2nd FF output (2-cycle latency from serial_in).
//  Start detect: in IDLE, a falling edge of serial_bit (prev=1, now=0) at cycle t0 -> START.
//  FSM states IDLE, START, DATA, STOP; timer restarts on every state entry:
//   - START: at t0+HALF, if serial_bit=0 -> DATA with bit count=0; else false start -> IDLE,
//     with no shift pulse and no status change.
//   - DATA: shift_enable=1 for exactly one cycle at t0+HALF+k*CLKS_PER_BIT, k=1..DATA_BITS.
//     After the DATA_BITS-th pulse -> STOP.
//   - STOP: at t0+HALF+(DATA_BITS+1)*CLKS_PER_BIT, sample serial_bit, then -> IDLE.
//  Stop sample = 1:
//   - rx_data<=sr_data, data_ready<=1, framing_error<=0.
//   - If data_ready was already 1 and data_read is not high that cycle, also overrun_error<=1.
//  Stop sample = 0:
//   - framing_error<=1; rx_data and data_ready unchanged.
//  data_read=1: data_ready<=0 and overrun_error<=0 next edge.
//   - Same cycle as a good stop: the load wins (data_ready=1, overrun not set).
//  Serial line ignored outside IDLE/sample points; a low line held after STOP re-arms only on a fresh falling edge.
//  Because stp shifts toward bit 0, the first received bit lands in rx_data[0].
// STRUCTURE
//  rx_frame_pkg: state_t enum {IDLE,START,DATA,STOP}; localparam TIMER_W=$clog2(CLKS_PER_BIT+1),
//   BITCNT_W=$clog2(DATA_BITS+1).
//  Sub-modules: flex_counter (NUM_CNT_BITS, clear, count_enable, rollover_val, rollover_flag), two instances:
//   - bit timer: rollover_val HALF in START, CLKS_PER_BIT otherwise.
//   - data-bit counter: counts shift pulses.
//  Synchronizer, FSM, and output buffer stay in this module.
// TESTING (CLKS_PER_BIT=10, DATA_BITS=4, real stp_4bit wired in, serial driven at negedge)
//  1 Reset -> rx_data=0000, data_ready=0, framing/overrun=0, busy=0, shift_enable=0; serial_bit=1 after release.
//  2 Frame start 0, bits 0,1,0,1, stop 1 -> 4 shift pulses exactly 10 clk apart,
//    rx_data=1010, data_ready=1, framing_error=0.
//  3 Frame bits 1,1,0,0 with stop 0 -> framing_error=1; rx_data still 1010; data_ready unchanged.
//  4 Low glitch of 3 clk on idle line -> no shift_enable; busy high ~HALF clk then 0; no status change.
//  5 Two good frames 0011 then 0110, no data_read -> overrun_error=1, rx_data=0110;
//    data_read pulse -> data_ready=0, overrun_error=0.
//  6 n_rst pulsed after 2nd shift pulse -> outputs 0 immediately;
//    next frame 1001 received correctly, rx_data=1001.

Source files
------------

// File: rtl/rx_frame_pkg.sv
// Shared types and helpers for the receive-side frame controller.
package rx_frame_pkg;

  // Default frame geometry: 4 data bits, 10 clk cycles per bit period.
  localparam int DATA_BITS_DEF    = 4;
  localparam int CLKS_PER_BIT_DEF = 10;

  // Frame reception phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Bits needed for a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter with programmable rollover.
// The count runs 1..rollover_val and then wraps back to 1, so once it is
// running the flag recurs exactly every rollover_val enabled cycles.
// rollover_flag is high while the count equals rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;

  // Count register: clear has priority over counting; wrap goes to 1, not 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      if (r_count == rollover_val) begin
        r_count <= NUM_CNT_BITS'(1);
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign rollover_flag = (r_count == rollover_val);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive-side frame controller for the stp shift register.
// Synchronises the serial line, qualifies the start bit at mid-bit, pulses
// shift_enable at the centre of each data bit, checks the stop bit and then
// moves the shift register's parallel word into a held output buffer with
// ready / overrun / framing status.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int DATA_BITS    = DATA_BITS_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic [DATA_BITS-1:0] sr_data,
  input  logic                 data_read,
  output logic                 serial_bit,
  output logic                 shift_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  // Half a bit period: distance from the start-bit edge to its midpoint.
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int TMR_W = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W = cnt_width(DATA_BITS);

  // Synchroniser and edge detector.
  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_fall;

  // FSM.
  state_t r_state;
  state_t w_next_state;
  logic   w_shift;
  logic   w_stop_sample;

  // Counter controls.
  logic             w_tmr_clear;
  logic             w_tmr_flag;
  logic [TMR_W-1:0] w_tmr_roll;
  logic             w_bit_clear;
  logic             w_bit_flag;

  // Held output buffer.
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_data_ready;
  logic                 r_framing_error;
  logic                 r_overrun_error;

  // Two-stage synchroniser plus previous-value FF for falling-edge detection.
  // All three reset to the idle level so releasing reset never fakes a start edge.
  // NOTE: non-blocking assignments make each FF sample the pre-edge value of
  // the one before it; blocking here would collapse the chain into a wire.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = r_prev & ~r_sync2;

  // Bit-period timer: half period while qualifying the start bit, full
  // period afterwards; held at zero whenever the FSM is (or is about to be) idle.
  assign w_tmr_roll  = (r_state == START) ? TMR_W'(HALF) : TMR_W'(CLKS_PER_BIT);
  assign w_tmr_clear = (w_next_state == IDLE);

  flex_counter #(
    .NUM_CNT_BITS (TMR_W)
  ) u_bit_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_tmr_clear),
    .count_enable  (1'b1),
    .rollover_val  (w_tmr_roll),
    .rollover_flag (w_tmr_flag)
  );

  // Data-bit counter: counts shift pulses; its flag marks the last data bit done.
  assign w_bit_clear = (r_state != DATA);

  flex_counter #(
    .NUM_CNT_BITS (BIT_W)
  ) u_data_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_bit_clear),
    .count_enable  (w_shift),
    .rollover_val  (BIT_W'(DATA_BITS)),
    .rollover_flag (w_bit_flag)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and per-cycle strobes.
  // NOTE: every output of this block gets a default before the case so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_shift       = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_next_state = START;
        end
      end
      START: begin
        // Mid start bit: still low means a real frame, high means a glitch.
        if (w_tmr_flag) begin
          w_next_state = r_sync2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_bit_flag) begin
          w_next_state = STOP;
        end else if (w_tmr_flag) begin
          w_shift = 1'b1;
        end
      end
      STOP: begin
        if (w_tmr_flag) begin
          w_stop_sample = 1'b1;
          w_next_state  = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Output buffer and status flags. A good stop loads the word; a
  // simultaneous data_read cannot drop that fresh word, only clear overrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_data       <= '0;
      r_data_ready    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun_error <= 1'b0;
    end else if (w_stop_sample && r_sync2) begin
      r_rx_data       <= sr_data;
      r_data_ready    <= 1'b1;
      r_framing_error <= 1'b0;
      if (data_read) begin
        r_overrun_error <= 1'b0;
      end else if (r_data_ready) begin
        r_overrun_error <= 1'b1;
      end
    end else begin
      if (w_stop_sample) begin
        r_framing_error <= 1'b1;
      end
      if (data_read) begin
        r_data_ready    <= 1'b0;
        r_overrun_error <= 1'b0;
      end
    end
  end

  assign serial_bit    = r_sync2;
  assign shift_enable  = w_shift;
  assign rx_data       = r_rx_data;
  assign data_ready    = r_data_ready;
  assign framing_error = r_framing_error;
  assign overrun_error = r_overrun_error;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl with a behavioural 4-bit
// serial-to-parallel register on the sr_data side and a frame-level
// reference model of the receiver status.
module tb_rx_frame_ctrl;

  localparam int CLKS = 10;
  localparam int NB   = 4;
  localparam int HALF = CLKS / 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          serial_in;
  logic          data_read;
  logic [NB-1:0] sr_data;
  logic          serial_bit;
  logic          shift_enable;
  logic [NB-1:0] rx_data;
  logic          data_ready;
  logic          framing_error;
  logic          overrun_error;
  logic          busy;

  always #5 clk = ~clk;

  // stp_4bit: shifts toward bit 0, new bit enters at the MSB, resets to ones.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sr_data <= '1;
    else if (shift_enable) sr_data <= {serial_bit, sr_data[NB-1:1]};
  end

  rx_frame_ctrl #(
    .DATA_BITS    (NB),
    .CLKS_PER_BIT (CLKS)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .sr_data       (sr_data),
    .data_read     (data_read),
    .serial_bit    (serial_bit),
    .shift_enable  (shift_enable),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .busy          (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pulse_q[$];

  // Reference model of the receiver's visible status.
  logic [NB-1:0] m_rx;
  logic          m_ready;
  logic          m_fe;
  logic          m_ov;

  // Record the cycle index of every shift pulse, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (shift_enable === 1'b1) pulse_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rx = '0; m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endtask

  // Frame outcome from the stop bit and whether the consumer read that cycle.
  task automatic model_frame(input logic [NB-1:0] d, input logic stop, input logic rd);
    if (stop) begin
      m_ov    = rd ? 1'b0 : (m_ready | m_ov);
      m_rx    = d;
      m_ready = 1'b1;
      m_fe    = 1'b0;
    end else begin
      m_fe = 1'b1;
      if (rd) begin m_ready = 1'b0; m_ov = 1'b0; end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".rx_data"},       rx_data,       m_rx);
    check({tag, ".data_ready"},    data_ready,    m_ready);
    check({tag, ".framing_error"}, framing_error, m_fe);
    check({tag, ".overrun_error"}, overrun_error, m_ov);
    check({tag, ".busy"},          busy,          1'b0);
  endtask

  task automatic check_pulses(input string tag, input int exp_n);
    check({tag, ".npulse"}, pulse_q.size(), exp_n);
    for (int i = 1; i < pulse_q.size(); i++)
      check($sformatf("%s.spacing%0d", tag, i), pulse_q[i] - pulse_q[i-1], CLKS);
  endtask

  // Start bit, NB data bits LSB first, stop bit, then idle line.
  task automatic send_frame(input logic [NB-1:0] d, input logic stop);
    @(negedge clk);
    serial_in = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      serial_in = d[i];
      repeat (CLKS) @(negedge clk);
    end
    serial_in = stop;
    repeat (CLKS) @(negedge clk);
    serial_in = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_frame(input string tag, input logic [NB-1:0] d, input logic stop);
    pulse_q.delete();
    send_frame(d, stop);
    model_frame(d, stop, 1'b0);
    check_pulses(tag, NB);
    check_state(tag);
  endtask

  task automatic do_glitch(input string tag, input int len);
    pulse_q.delete();
    @(negedge clk);
    serial_in = 1'b0;
    repeat (len) @(negedge clk);
    serial_in = 1'b1;
    repeat (CLKS + 4) @(negedge clk);
    check_pulses(tag, 0);
    check_state(tag);
  endtask

  task automatic do_read(input string tag);
    @(negedge clk);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    m_ready = 1'b0;
    m_ov    = 1'b0;
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int sel;
    logic [NB-1:0] d;

    // 1: reset state.
    n_rst = 1'b0; serial_in = 1'b1; data_read = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("rst_hold");
    check("rst_hold.shift_enable", shift_enable, 1'b0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check_state("rst_rel");
    check("rst_rel.serial_bit", serial_bit, 1'b1);
    check("rst_rel.shift_enable", shift_enable, 1'b0);

    // 2: good frame, bits 0,1,0,1 in time order.
    do_frame("good1010", 4'b1010, 1'b1);

    // 3: bits 1,1,0,0 with a low stop bit.
    do_frame("fe0011", 4'b0011, 1'b0);

    // 4: three-cycle glitch on the idle line; busy only briefly.
    pulse_q.delete();
    @(negedge clk);
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    @(negedge clk);
    check("glitch.busy_hi", busy, 1'b1);
    repeat (6) @(negedge clk);
    check("glitch.busy_lo", busy, 1'b0);
    repeat (6) @(negedge clk);
    check_pulses("glitch3", 0);
    check_state("glitch3");

    // 5: two unread frames overrun, then a read clears status.
    do_read("read0");
    do_frame("ov_a", 4'b0011, 1'b1);
    do_frame("ov_b", 4'b0110, 1'b1);
    do_read("read1");

    // Load wins over a read in the same cycle as the stop sample.
    do_frame("pre_lw", 4'b0101, 1'b1);
    pulse_q.delete();
    fork
      send_frame(4'b1100, 1'b1);
      begin
        @(negedge clk);
        repeat (HALF + (NB + 1) * CLKS + 2) @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
      end
    join
    model_frame(4'b1100, 1'b1, 1'b1);
    check_pulses("loadwins", NB);
    check_state("loadwins");

    // 6: reset pulsed after the second shift pulse of a frame.
    do_frame("pre_fe", 4'b0111, 1'b0);
    pulse_q.delete();
    fork
      send_frame(4'b0110, 1'b1);
      begin
        k = 0;
        while (pulse_q.size() < 2 && k < 400) begin
          @(negedge clk);
          k++;
        end
        check("midrst.wait_pulses", (k < 400), 1'b1);
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        check_state("midrst");
        check("midrst.shift_enable", shift_enable, 1'b0);
      end
    join
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst.serial_bit", serial_bit, 1'b1);
    check_state("midrst_rel");
    do_frame("after_rst", 4'b1001, 1'b1);

    // Randomised mix of frames, glitches and reads.
    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 9));
      d   = NB'($urandom_range(0, 15));
      if (sel <= 4)      do_frame($sformatf("rnd%0d.good", i), d, 1'b1);
      else if (sel <= 6) do_frame($sformatf("rnd%0d.bad", i), d, 1'b0);
      else if (sel <= 8) do_glitch($sformatf("rnd%0d.glitch", i), int'($urandom_range(1, HALF - 1)));
      else               do_read($sformatf("rnd%0d.read", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
